conv_line_buffer: RTL

Raster-to-column converter directly upstream of the 5x5 convolution stage. Accepts one pixel per accepted cycle in row-major order and buffers the previous four image rows. Each accepted pixel produces one registered 5-pixel vertical column (top row first) plus a shift-enable for the convolution stage. A `conv_valid` flag marks the cycles in which the convolution output corresponds to a complete in-image 5x5 window.

---
 rtl/conv_line_buffer_if.sv | 56 +++++
 rtl/conv_line_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_line_buffer_if.sv
// ---------------------------------------------------------------------------
// conv_line_buffer_if
//   Handshake/data bundle between a raster pixel source, the line buffer and
//   the 5x5 convolution stage that consumes its columns.
//
//   Signals
//     in_valid   : pixel valid this cycle (the line buffer is always ready)
//     pixel      : signed raster pixel, row-major order
//     out1..out5 : registered vertical column, out1 = row r-4 (top),
//                  out5 = row r (current)
//     out_en     : shift enable for the convolution stage
//     conv_valid : convolution result is a complete in-image 5x5 window
//     frame_done : one-cycle pulse aligned with the last window of a frame
//     win_row/win_col : top-left window coordinate, only present when
//                  CONV_WIN_COORD_EN is defined
//
//   Modports
//     master : pixel source / convolution side (drives in_valid, pixel)
//     slave  : conv_line_buffer
// ---------------------------------------------------------------------------
interface conv_line_buffer_if #(
    parameter int BIT_WIDTH  = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
);
    logic                        in_valid;
    logic signed [BIT_WIDTH-1:0] pixel;
    logic signed [BIT_WIDTH-1:0] out1;
    logic signed [BIT_WIDTH-1:0] out2;
    logic signed [BIT_WIDTH-1:0] out3;
    logic signed [BIT_WIDTH-1:0] out4;
    logic signed [BIT_WIDTH-1:0] out5;
    logic                        out_en;
    logic                        conv_valid;
    logic                        frame_done;
`ifdef CONV_WIN_COORD_EN
    logic [$clog2(IMG_HEIGHT)-1:0] win_row;
    logic [$clog2(IMG_WIDTH)-1:0]  win_col;
`endif

    modport master (
        output in_valid, pixel,
        input  out1, out2, out3, out4, out5, out_en, conv_valid, frame_done
`ifdef CONV_WIN_COORD_EN
        , input win_row, win_col
`endif
    );

    modport slave (
        input  in_valid, pixel,
        output out1, out2, out3, out4, out5, out_en, conv_valid, frame_done
`ifdef CONV_WIN_COORD_EN
        , output win_row, win_col
`endif
    );
endinterface

// File: rtl/conv_line_buffer.sv
// ---------------------------------------------------------------------------
// conv_line_buffer
//   Raster-to-column converter feeding a 5x5 convolution stage. Every
//   accepted pixel produces one registered 5-pixel vertical column built from
//   the pixel itself and the same column of the four previous rows, which are
//   kept in four line memories. A two-stage flag pipeline marks the cycle in
//   which the convolution stage holds a complete in-image 5x5 window.
//
//   Parameters
//     BIT_WIDTH  : pixel width (signed)
//     IMG_WIDTH  : pixels per row, >= 5
//     IMG_HEIGHT : rows per frame, >= 5
//
//   Ports
//     clk : rising-edge clock
//     rst : asynchronous, active-high reset
//     bus : conv_line_buffer_if.slave (in_valid/pixel in; column, out_en,
//           conv_valid, frame_done and optional window coordinates out)
//
//   Optional feature
//     CONV_WIN_COORD_EN : when defined, win_row/win_col carry the top-left
//     coordinate (row-4, col-4) of the window flagged by conv_valid. When
//     undefined those ports and their pipeline registers are absent.
// ---------------------------------------------------------------------------
module conv_line_buffer #(
    parameter int BIT_WIDTH  = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                clk,
    input  logic                rst,
    conv_line_buffer_if.slave   bus
);
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam int NLINES = 4;

    typedef enum logic {
        S_FILL = 1'b0,   // rows 0..3: columns emitted, no full window yet
        S_RUN  = 1'b1    // rows 4..: window valid once col >= 4
    } state_t;

    // -----------------------------------------------------------------------
    // Raster position and frame state
    // -----------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [CW-1:0]  col_q,   col_d;
    logic [RW-1:0]  row_q,   row_d;

    logic accept;
    logic col_last;
    logic row_last;
    logic win_d;

    assign accept   = bus.in_valid;
    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    // Frame wrap: the next accepted pixel is (0,0) of a new
                    // frame, so the upper rows are from the old frame again.
                    row_d   = '0;
                    state_d = S_FILL;
                end else begin
                    row_d = row_q + RW'(1);
                    case (state_q)
                        S_FILL:  if (row_q == RW'(NLINES - 1)) state_d = S_RUN;
                        default: state_d = state_q;
                    endcase
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // A window is complete once four rows sit above the pixel and four
    // columns sit to its left. The state already encodes row >= 4.
    assign win_d = (state_q == S_RUN) && (col_q >= CW'(NLINES));

    // -----------------------------------------------------------------------
    // Line memories. Not reset: rows 0..3 of every frame overwrite a column
    // before any flagged window can read it, so stale contents never reach a
    // conv_valid window.
    // -----------------------------------------------------------------------
    logic signed [BIT_WIDTH-1:0] lb_mem [NLINES][IMG_WIDTH];
    logic signed [BIT_WIDTH-1:0] lb_rd  [NLINES];

    always_comb begin
        for (int k = 0; k < NLINES; k++) begin
            lb_rd[k] = lb_mem[k][col_q];
        end
    end

    // Each accept pushes the column one line deeper: LB0 takes the new
    // pixel, LBk takes what LB(k-1) held before this edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mem[0][col_q] <= bus.pixel;
            for (int k = 1; k < NLINES; k++) begin
                lb_mem[k][col_q] <= lb_rd[k-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Column output and flag pipeline
    //   edge k   : column, out_en, window flag and last-pixel flag registered
    //   edge k+1 : conv stage shifts; conv_valid/frame_done registered
    // -----------------------------------------------------------------------
    logic signed [BIT_WIDTH-1:0] colv_q [NLINES+1];   // [0] = top row (r-4)
    logic out_en_q;
    logic win_q;
    logic last_q;
    logic conv_valid_q;
    logic frame_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FILL;
            col_q        <= '0;
            row_q        <= '0;
            for (int k = 0; k <= NLINES; k++) colv_q[k] <= '0;
            out_en_q     <= 1'b0;
            win_q        <= 1'b0;
            last_q       <= 1'b0;
            conv_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_en_q     <= accept;
            // Gating with out_en makes a stalled window pulse only once:
            // win_q holds across a gap but out_en has already dropped.
            conv_valid_q <= out_en_q & win_q;
            last_q       <= accept & col_last & row_last;
            frame_done_q <= last_q;
            if (accept) begin
                state_q <= state_d;
                col_q   <= col_d;
                row_q   <= row_d;
                win_q   <= win_d;
                colv_q[NLINES] <= bus.pixel;
                for (int k = 0; k < NLINES; k++) begin
                    colv_q[k] <= lb_rd[NLINES-1-k];
                end
            end
        end
    end

    assign bus.out1       = colv_q[0];
    assign bus.out2       = colv_q[1];
    assign bus.out3       = colv_q[2];
    assign bus.out4       = colv_q[3];
    assign bus.out5       = colv_q[4];
    assign bus.out_en     = out_en_q;
    assign bus.conv_valid = conv_valid_q;
    assign bus.frame_done = frame_done_q;

`ifdef CONV_WIN_COORD_EN
    // -----------------------------------------------------------------------
    // Window coordinates, pipelined alongside the window flag so they line
    // up with conv_valid. They hold between windows.
    // -----------------------------------------------------------------------
    logic [RW-1:0] wr_q, win_row_q;
    logic [CW-1:0] wc_q, win_col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= '0;
            wc_q      <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            if (accept) begin
                wr_q <= row_q - RW'(NLINES);
                wc_q <= col_q - CW'(NLINES);
            end
            if (out_en_q && win_q) begin
                win_row_q <= wr_q;
                win_col_q <= wc_q;
            end
        end
    end

    assign bus.win_row = win_row_q;
    assign bus.win_col = win_col_q;
`endif

endmodule
